// File: rtl/fifo_ctrl_pkg.sv
// ============================================================================
//  fifo_ctrl_pkg
//  Shared types and constants for the FIFO write arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int STAT_CNT_W = 16;

    // Beat counter is wide enough for the largest permitted burst (15).
    localparam int BEAT_W = 4;

    function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
        return (v == '1) ? v : v + STAT_CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  rr_pick
//  Combinational round-robin selector: first requester after last_grant.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    logic [IW-1:0] cand;

    // Walk the ring explicitly so non-power-of-2 sizes wrap correctly.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IW'(1);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arb.sv
// ============================================================================
//  fifo_wr_arb
//  Round-robin burst arbiter for N_REQ writers into one FIFO write port.
//  Optional per-requester write counters: define FIFO_WR_ARB_STATS_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arb
    import fifo_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     fifo_wr_en,
    output logic [DW-1:0]            fifo_wdata,
    input  logic                     fifo_full,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic [$clog2(N_REQ)-1:0] stat_sel,
    output logic [STAT_CNT_W-1:0]    stat_cnt
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(BURST_LEN);
    localparam logic [IW-1:0]     LAST_IDX   = IW'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     srv_idx;
    logic              srv_req;
    logic              wr;
    logic [DW-1:0]     req_data_arr [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // rst_n gates the write path so ack/wr_en drop the instant reset asserts.
    always_comb begin
        srv_idx    = (state_q == LOCK) ? owner_q : pick_idx;
        srv_req    = (state_q == LOCK) ? req[owner_q] : pick_valid;
        wr         = srv_req & ~fifo_full & rst_n;
        ack        = '0;
        fifo_wr_en = wr;
        fifo_wdata = '0;
        if (wr) begin
            ack[srv_idx] = 1'b1;
            fifo_wdata   = req_data_arr[srv_idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (wr && (BURST_LAST == BEAT_W'(1))) begin
                        last_grant_d = pick_idx;
                    end else begin
                        // A full FIFO still locks the owner, with no beats yet.
                        state_d = LOCK;
                        owner_d = pick_idx;
                        beat_d  = wr ? BEAT_W'(1) : '0;
                    end
                end
            end
            LOCK: begin
                if (!req[owner_q]) begin
                    state_d      = IDLE;
                    beat_d       = '0;
                    last_grant_d = owner_q;
                end else if (wr) begin
                    if (beat_q + BEAT_W'(1) == BURST_LAST) begin
                        state_d      = IDLE;
                        beat_d       = '0;
                        last_grant_d = owner_q;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            owner_q      <= '0;
            last_grant_q <= LAST_IDX;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy  = (state_q == LOCK);
    assign owner = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_CNT_W-1:0] cnt_q [N_REQ];
    logic [STAT_CNT_W-1:0] cnt_d [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = ack[i] ? sat_inc(cnt_q[i]) : cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stat_cnt = (int'(stat_sel) < N_REQ) ? cnt_q[stat_sel] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// ============================================================================
//  tb_fifo_wr_arb
//  Randomised and directed checks of fifo_wr_arb against a tenure-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_full;
    logic [1:0]      owner;
    logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [1:0]      stat_sel;
    logic [15:0]     stat_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: tenure owner, beats taken, last finished owner.
    int m_busy, m_owner, m_beats, m_last, m_sel;
    logic [N-1:0]  exp_ack;
    logic [DW-1:0] exp_data;

    fifo_wr_arb #(.N_REQ(N), .DW(DW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .owner      (owner),
        .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_beats = 0; m_last = N - 1; m_sel = -1;
    endtask

    task automatic model_eval();
        m_sel = -1;
        if (m_busy != 0) begin
            if (req[m_owner]) m_sel = m_owner;
        end else begin
            for (int k = 1; k <= N; k++)
                if (m_sel < 0 && req[(m_last + k) % N]) m_sel = (m_last + k) % N;
        end
        exp_ack  = '0;
        exp_data = '0;
        if (m_sel >= 0 && !fifo_full && rst_n) begin
            exp_ack[m_sel] = 1'b1;
            exp_data       = req_data[m_sel*DW +: DW];
        end
    endtask

    task automatic apply(input logic [N-1:0] r, input logic f, input logic [N*DW-1:0] d);
        req = r; fifo_full = f; req_data = d;
        #1;
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) begin
            if (m_busy == 0) begin
                if (m_sel >= 0) begin
                    if (!fifo_full && BL == 1) m_last = m_sel;
                    else begin
                        m_busy = 1; m_owner = m_sel; m_beats = fifo_full ? 0 : 1;
                    end
                end
            end else if (!req[m_owner]) begin
                m_busy = 0; m_last = m_owner;
            end else if (!fifo_full) begin
                m_beats++;
                if (m_beats == BL) begin m_busy = 0; m_last = m_owner; end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; fifo_full = 1'b0; req_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply(4'b1111, 1'b0, {$urandom});
        checks++;
        if (ack !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset: ack=%b wr_en=%b busy=%b owner=%0d, required 0000 0 0 0",
                     ack, fifo_wr_en, busy, owner);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(4'b0001, 1'b0, {24'h123456, 8'hA5});
            checks++;
            if (ack !== 4'b0001 || fifo_wdata !== 8'hA5 || fifo_wr_en !== 1'b1 ||
                busy !== (c != 0)) begin
                errors++;
                $display("FAIL single_beat%0d: ack=%b data=%h wr_en=%b busy=%b, required 0001 a5 1 %0d",
                         c, ack, fifo_wdata, fifo_wr_en, busy, c != 0);
            end
            adv();
        end
        apply(4'b0000, 1'b0, '0);
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_wdata !== 8'h00) begin
            errors++;
            $display("FAIL single_end: busy=%b ack=%b wr_en=%b data=%h, required 0 0000 0 00",
                     busy, ack, fifo_wr_en, fifo_wdata);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            apply(4'b1111, 1'b0, {$urandom});
            want = 4'b0001 << ((c / 4) % 4);
            checks++;
            if (ack !== want || fifo_wdata !== exp_data || $countones(ack) > 1) begin
                errors++;
                $display("FAIL rr_cycle%0d: ack=%b data=%h, required ack=%b data=%h",
                         c, ack, fifo_wdata, want, exp_data);
            end
            adv();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        apply(4'b0100, 1'b0, {$urandom});
        checks++;
        if (ack !== 4'b0100 || fifo_wdata !== exp_data) begin
            errors++;
            $display("FAIL stall_first: ack=%b data=%h, required 0100 %h", ack, fifo_wdata, exp_data);
        end
        adv();
        for (int c = 0; c < 3; c++) begin
            apply(4'b1111, 1'b1, {$urandom});
            checks++;
            if (ack !== 4'b0000 || fifo_wr_en !== 1'b0 || owner !== 2'd2 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_full%0d: ack=%b wr_en=%b owner=%0d busy=%b, required 0000 0 2 1",
                         c, ack, fifo_wr_en, owner, busy);
            end
            adv();
        end
        for (int c = 0; c < 3; c++) begin
            apply(4'b1111, 1'b0, {$urandom});
            checks++;
            if (ack !== 4'b0100 || fifo_wdata !== exp_data || owner !== 2'd2) begin
                errors++;
                $display("FAIL stall_resume%0d: ack=%b data=%h owner=%0d, required 0100 %h 2",
                         c, ack, fifo_wdata, owner, exp_data);
            end
            adv();
        end
        apply(4'b0000, 1'b0, '0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_drop();
        do_reset();
        repeat (2) begin
            apply(4'b0010, 1'b0, {$urandom});
            adv();
        end
        apply(4'b1000, 1'b0, {$urandom});
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b1 || owner !== 2'd1) begin
            errors++;
            $display("FAIL drop_cycle: ack=%b busy=%b owner=%0d, required 0000 1 1", ack, busy, owner);
        end
        adv();
        apply(4'b1000, 1'b0, {$urandom});
        checks++;
        if (ack !== 4'b1000 || busy !== 1'b0 || fifo_wdata !== exp_data) begin
            errors++;
            $display("FAIL drop_next: ack=%b busy=%b data=%h, required 1000 0 %h",
                     ack, busy, fifo_wdata, exp_data);
        end
        adv();
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(4'b1000, 1'b0, {$urandom});
        adv();
        apply(4'b1111, 1'b0, {$urandom});
        checks++;
        if (ack !== 4'b1000 || busy !== 1'b1 || owner !== 2'd3) begin
            errors++;
            $display("FAIL midrst_before: ack=%b busy=%b owner=%0d, required 1000 1 3", ack, busy, owner);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_assert: ack=%b busy=%b wr_en=%b, required 0000 0 0",
                     ack, busy, fifo_wr_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1111, 1'b0, {$urandom});
        checks++;
        if (ack !== 4'b0001 || fifo_wdata !== req_data[7:0]) begin
            errors++;
            $display("FAIL midrst_release: ack=%b data=%h, required 0001 %h",
                     ack, fifo_wdata, req_data[7:0]);
        end
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            apply(N'($urandom), ($urandom_range(0, 3) == 0), {$urandom});
            checks++;
            if (ack !== exp_ack || fifo_wdata !== exp_data || fifo_wr_en !== (|exp_ack) ||
                busy !== (m_busy != 0) || (m_busy != 0 && int'(owner) != m_owner)) begin
                errors++;
                $display("FAIL random%0d: ack=%b data=%h wr_en=%b busy=%b owner=%0d, required %b %h %b %0d %0d",
                         c, ack, fifo_wdata, fifo_wr_en, busy, owner,
                         exp_ack, exp_data, |exp_ack, m_busy, m_owner);
            end
            adv();
        end
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        stat_sel = 2'd0;
        #1;
        checks++;
        if (stat_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL stats_reset: cnt=%h, required 0000", stat_cnt);
        end
        for (int c = 0; c < 70000; c++) begin
            apply(4'b0001, 1'b0, {$urandom});
            adv();
        end
        apply(4'b0000, 1'b0, '0);
        checks++;
        if (stat_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_sat: cnt=%h, required ffff", stat_cnt);
        end
        stat_sel = 2'd1;
        #1;
        checks++;
        if (stat_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL stats_other: cnt=%h, required 0000", stat_cnt);
        end
        stat_sel = 2'd0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_sel = 2'd0;
`endif
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_random();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
